// File: rtl/nmr_bstrm_cmd_loader.sv
// nmr_bstrm_cmd_loader
//   Accepts host command words for the NMR bitstream controller, checks
//   them for loop-nesting, zero-loop-count and overflow errors, and writes
//   the legal ones into the command SRAM one word at a time.
//
// Ports
//   CLK, RST         clock; synchronous active-low reset
//   CMD_DAT/VALID    host command word and its valid
//   CMD_READY        loader takes a word this cycle
//   CMD_CLR          abort current load, restart at address 0
//   SEQ_BUSY         bitstream controller running; SRAM must not be written
//   SRAM_ADDR/WR_DAT/WE  SRAM write port
//   LOAD_DONE        complete sequence stored (seq_end word written)
//   LOAD_ERR/ERR_CODE    load aborted: 01 nesting, 10 zero count, 11 overflow
//   WORD_CNT         number of words written
//
// Word layout: [31] polarity, [30] seq_end, [29] loop_start,
//              [28] loop_stop, [27:24] mux_sel, [23:0] data
module nmr_bstrm_cmd_loader #(
  parameter int SRAM_ADDR_WIDTH = 8,
  parameter int SRAM_DAT_WIDTH  = 32
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [SRAM_DAT_WIDTH-1:0]  CMD_DAT,
  input  logic                       CMD_VALID,
  output logic                       CMD_READY,
  input  logic                       CMD_CLR,
  input  logic                       SEQ_BUSY,
  output logic [SRAM_ADDR_WIDTH-1:0] SRAM_ADDR,
  output logic [SRAM_DAT_WIDTH-1:0]  SRAM_WR_DAT,
  output logic                       SRAM_WE,
  output logic                       LOAD_DONE,
  output logic                       LOAD_ERR,
  output logic [1:0]                 ERR_CODE,
  output logic [SRAM_ADDR_WIDTH:0]   WORD_CNT
);

  typedef enum logic [1:0] {LOAD, WR, DONE, ERR} state_t;

  localparam logic [SRAM_ADDR_WIDTH-1:0] PTR_MAX = '1;
  localparam logic [1:0] E_NONE = 2'b00, E_NEST = 2'b01,
                         E_ZERO = 2'b10, E_OVF  = 2'b11;

  state_t                      state_q, state_d;
  logic [SRAM_DAT_WIDTH-1:0]   word_q, word_d;
  logic [SRAM_ADDR_WIDTH-1:0]  ptr_q, ptr_d;
  logic [SRAM_ADDR_WIDTH:0]    cnt_q, cnt_d;
  logic                        lo_q, lo_d;
  logic [1:0]                  err_q, err_d;

  logic xfer, ls, lp, se, dz, lo_after;
  logic [1:0] code;

  assign ls = CMD_DAT[29];
  assign lp = CMD_DAT[28];
  assign se = CMD_DAT[30];
  assign dz = (CMD_DAT[23:0] == 24'd0);

  // Ready is masked during reset so no transfer is taken while RST is low.
  assign CMD_READY   = (state_q == LOAD) && !SEQ_BUSY && RST;
  assign xfer        = CMD_VALID && CMD_READY;
  // Write is a Mealy output of WR; reset or clear in that cycle kills it.
  assign SRAM_WE     = (state_q == WR) && !SEQ_BUSY && RST && !CMD_CLR;
  assign SRAM_ADDR   = ptr_q;
  assign SRAM_WR_DAT = word_q;
  assign LOAD_DONE   = (state_q == DONE);
  assign LOAD_ERR    = (state_q == ERR);
  assign ERR_CODE    = err_q;
  assign WORD_CNT    = cnt_q;

  // Legality check of the incoming word against the current loop state.
  // seq_end is judged against the loop state after this word, so a word
  // that closes the last loop may also end the sequence.
  always_comb begin
    code     = E_NONE;
    lo_after = lo_q;
    if (ls && lp) begin
      if (lo_q)    code = E_NEST;
      else if (dz) code = E_ZERO;
      lo_after = 1'b0;
    end else if (ls) begin
      if (lo_q)    code = E_NEST;
      else if (dz) code = E_ZERO;
      lo_after = 1'b1;
    end else if (lp) begin
      if (!lo_q)   code = E_NEST;
      lo_after = 1'b0;
    end
    if (code == E_NONE && se && lo_after)               code = E_NEST;
    if (code == E_NONE && !se && ptr_q == PTR_MAX)      code = E_OVF;
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    err_d   = err_q;
    if (CMD_CLR) begin
      state_d = LOAD;
      ptr_d   = '0;
      cnt_d   = '0;
      lo_d    = 1'b0;
      err_d   = E_NONE;
    end else begin
      case (state_q)
        LOAD: if (xfer) begin
          word_d = CMD_DAT;
          if (code != E_NONE) begin
            state_d = ERR;
            err_d   = code;
          end else begin
            state_d = WR;
            // A legal word always reaches the SRAM unless cleared or
            // reset, both of which clear the flag anyway, so the loop
            // state can be committed here.
            lo_d    = lo_after;
          end
        end
        WR: if (!SEQ_BUSY) begin
          // Saturate: only a seq_end word can be written at PTR_MAX.
          ptr_d   = (ptr_q == PTR_MAX) ? ptr_q : ptr_q + 1'b1;
          cnt_d   = cnt_q + 1'b1;
          state_d = word_q[30] ? DONE : LOAD;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= LOAD;
      word_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      lo_q    <= 1'b0;
      err_q   <= E_NONE;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_nmr_bstrm_cmd_loader.sv
module tb_nmr_bstrm_cmd_loader;
  localparam int AW = 8;
  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [DW-1:0] CMD_DAT = '0;
  logic          CMD_VALID = 1'b0;
  logic          CMD_READY;
  logic          CMD_CLR = 1'b0;
  logic          SEQ_BUSY = 1'b0;
  logic [AW-1:0] SRAM_ADDR;
  logic [DW-1:0] SRAM_WR_DAT;
  logic          SRAM_WE;
  logic          LOAD_DONE;
  logic          LOAD_ERR;
  logic [1:0]    ERR_CODE;
  logic [AW:0]   WORD_CNT;

  nmr_bstrm_cmd_loader #(.SRAM_ADDR_WIDTH(AW), .SRAM_DAT_WIDTH(DW)) dut (
    .CLK(CLK), .RST(RST), .CMD_DAT(CMD_DAT), .CMD_VALID(CMD_VALID),
    .CMD_READY(CMD_READY), .CMD_CLR(CMD_CLR), .SEQ_BUSY(SEQ_BUSY),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_WR_DAT(SRAM_WR_DAT), .SRAM_WE(SRAM_WE),
    .LOAD_DONE(LOAD_DONE), .LOAD_ERR(LOAD_ERR), .ERR_CODE(ERR_CODE),
    .WORD_CNT(WORD_CNT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int fails  = 0;
  logic [39:0] sbq[$];
  int exp_ptr = 0;

  // Scoreboard monitor: every SRAM write must match the oldest expectation.
  always @(negedge CLK) begin
    logic [39:0] e;
    if (SRAM_WE === 1'b1) begin
      checks = checks + 1;
      if (sbq.size() == 0) begin
        fails = fails + 1;
        $display("FAIL unexpected_write actual addr=%0h data=%08h required none",
                 SRAM_ADDR, SRAM_WR_DAT);
      end else begin
        e = sbq.pop_front();
        if ({SRAM_ADDR, SRAM_WR_DAT} !== e) begin
          fails = fails + 1;
          $display("FAIL sram_write actual addr=%0h data=%08h required addr=%0h data=%08h",
                   SRAM_ADDR, SRAM_WR_DAT, e[39:32], e[31:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Offer one word; optionally expect it at the next model address.
  task automatic send(input logic [31:0] w, input bit exp_wr);
    int n;
    logic [7:0] a;
    if (exp_wr) begin
      a = exp_ptr[7:0];
      sbq.push_back({a, w});
      exp_ptr = exp_ptr + 1;
    end
    CMD_DAT = w;
    CMD_VALID = 1'b1;
    n = 0;
    @(negedge CLK);
    while (!CMD_READY && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 200) begin
      checks = checks + 1;
      fails = fails + 1;
      $display("FAIL ready_timeout actual=0 required=1");
    end
    @(posedge CLK);
    #1 CMD_VALID = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic clr();
    CMD_CLR = 1'b1;
    @(posedge CLK);
    #1 CMD_CLR = 1'b0;
    exp_ptr = 0;
    chk("clr_done", int'(LOAD_DONE), 0);
    chk("clr_err", int'(LOAD_ERR), 0);
    chk("clr_cnt", int'(WORD_CNT), 0);
  endtask

  initial begin
    // Reset with a valid word offered: nothing may be taken.
    CMD_DAT = 32'h40000001;
    CMD_VALID = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_ready", int'(CMD_READY), 0);
    chk("rst_we", int'(SRAM_WE), 0);
    chk("rst_addr", int'(SRAM_ADDR), 0);
    chk("rst_wdat", int'(SRAM_WR_DAT), 0);
    chk("rst_cnt", int'(WORD_CNT), 0);
    chk("rst_done", int'(LOAD_DONE), 0);
    chk("rst_err", int'(LOAD_ERR), 0);
    chk("rst_code", int'(ERR_CODE), 0);
    @(posedge CLK);
    #1 RST = 1'b1;
    CMD_VALID = 1'b0;

    // Legal sequence with one loop, back-to-back.
    send(32'h00000064, 1);
    send(32'h20000003, 1);
    send(32'h81000010, 1);
    send(32'h10000008, 1);
    send(32'h40000000, 1);
    idle(2);
    chk("seq_cnt", int'(WORD_CNT), 5);
    chk("seq_done", int'(LOAD_DONE), 1);
    chk("seq_err", int'(LOAD_ERR), 0);
    clr();

    // Nested loop_start.
    send(32'h20000002, 1);
    send(32'h20000002, 0);
    idle(2);
    chk("nest_err", int'(LOAD_ERR), 1);
    chk("nest_code", int'(ERR_CODE), 1);
    chk("nest_cnt", int'(WORD_CNT), 1);
    chk("nest_ready", int'(CMD_READY), 0);
    clr();
    chk("clr_code", int'(ERR_CODE), 0);

    // Zero loop count.
    send(32'h20000000, 0);
    idle(2);
    chk("zero_code", int'(ERR_CODE), 2);
    chk("zero_cnt", int'(WORD_CNT), 0);
    clr();

    // loop_stop with no loop open.
    send(32'h10000005, 0);
    idle(1);
    chk("stop_code", int'(ERR_CODE), 1);
    clr();

    // seq_end with a loop open.
    send(32'h20000001, 1);
    send(32'h40000000, 0);
    idle(1);
    chk("end_open_code", int'(ERR_CODE), 1);
    chk("end_open_cnt", int'(WORD_CNT), 1);
    clr();

    // Single word with both loop flags is legal and leaves no loop open.
    send(32'h30000004, 1);
    send(32'h40000000, 1);
    idle(2);
    chk("both_done", int'(LOAD_DONE), 1);
    chk("both_cnt", int'(WORD_CNT), 2);
    clr();

    // Overflow: 256 words without seq_end.
    for (int i = 0; i < 256; i++) send(32'h00000100 | i, i < 255);
    idle(2);
    chk("ovf_err", int'(LOAD_ERR), 1);
    chk("ovf_code", int'(ERR_CODE), 3);
    chk("ovf_cnt", int'(WORD_CNT), 255);
    chk("ovf_addr", int'(SRAM_ADDR), 255);
    clr();

    // SEQ_BUSY raised while in WR holds the write off.
    send(32'h00000011, 1);
    SEQ_BUSY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("busy_we", int'(SRAM_WE), 0);
      chk("busy_ready", int'(CMD_READY), 0);
    end
    @(posedge CLK);
    #1 SEQ_BUSY = 1'b0;
    @(negedge CLK);
    chk("busy_release_we", int'(SRAM_WE), 1);
    send(32'h40000000, 1);
    idle(2);
    chk("busy_cnt", int'(WORD_CNT), 2);
    chk("busy_done", int'(LOAD_DONE), 1);

    // Clear in DONE with a word offered: word dropped, restart at 0.
    CMD_DAT = 32'h40000077;
    CMD_VALID = 1'b1;
    CMD_CLR = 1'b1;
    @(posedge CLK);
    #1 CMD_CLR = 1'b0;
    CMD_VALID = 1'b0;
    exp_ptr = 0;
    chk("clr_done_state", int'(LOAD_DONE), 0);
    // Clear coincident with an actual transfer in LOAD.
    CMD_DAT = 32'h40000078;
    CMD_VALID = 1'b1;
    CMD_CLR = 1'b1;
    @(negedge CLK);
    chk("clr_xfer_ready", int'(CMD_READY), 1);
    @(posedge CLK);
    #1 CMD_CLR = 1'b0;
    CMD_VALID = 1'b0;
    idle(1);
    chk("clr_xfer_cnt", int'(WORD_CNT), 0);
    chk("clr_xfer_done", int'(LOAD_DONE), 0);
    send(32'h40000099, 1);
    idle(2);
    chk("after_clr_done", int'(LOAD_DONE), 1);
    chk("after_clr_cnt", int'(WORD_CNT), 1);

    // Reset while in WR suppresses the pending write.
    clr();
    send(32'h00000012, 0);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_mid_we", int'(SRAM_WE), 0);
    @(posedge CLK);
    #1 RST = 1'b1;
    exp_ptr = 0;
    chk("rst_mid_cnt", int'(WORD_CNT), 0);
    chk("rst_mid_addr", int'(SRAM_ADDR), 0);
    send(32'h40000013, 1);
    idle(3);
    chk("rst_mid_done", int'(LOAD_DONE), 1);
    chk("sb_empty", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/nmr_bstrm_cmd_loader.md
NMR_BSTRM_CMD_LOADER -- requirements
Module: nmr_bstrm_cmd_loader

Interface
REQ-001 SHALL have parameter SRAM_ADDR_WIDTH, default 8, the command SRAM address width.
REQ-002 SHALL have parameter SRAM_DAT_WIDTH, default 32, the command word width.
REQ-003 SHALL have port CLK input 1: the single clock; one clock; reset is synchronous and active-low.
REQ-004 SHALL have port RST input 1: the reset, synchronous and active-low (0 = reset).
REQ-005 SHALL have port CMD_DAT input SRAM_DAT_WIDTH: the host command word: [31] polarity, [30] seq_end, [29] loop_start, [28] loop_stop, [27:24] mux_sel, [23:0] data.
REQ-006 SHALL have port CMD_VALID input 1: the host word is valid.
REQ-007 SHALL have port CMD_READY output 1: the loader accepts a word this cycle.
REQ-008 SHALL have port CMD_CLR input 1: aborts the current load and restarts at address 0.
REQ-009 SHALL have port SEQ_BUSY input 1: the bitstream controller is running (its DONE is low).
REQ-010 SHALL have port SRAM_ADDR output SRAM_ADDR_WIDTH: the SRAM write address.
REQ-011 SHALL have port SRAM_WR_DAT output SRAM_DAT_WIDTH: the SRAM write data.
REQ-012 SHALL have port SRAM_WE output 1: the SRAM write enable, one cycle per word.
REQ-013 SHALL have port LOAD_DONE output 1: a complete, valid sequence is stored.
REQ-014 SHALL have port LOAD_ERR output 1: the load was aborted on error.
REQ-015 SHALL have port ERR_CODE output 2: 01 loop nesting, 10 zero loop count, 11 overflow.
REQ-016 SHALL have port WORD_CNT output SRAM_ADDR_WIDTH+1: the number of words written.

Function
REQ-017 SHALL implement the FSM states LOAD, WR, DONE, ERR.
REQ-018 In LOAD, CMD_READY SHALL equal !SEQ_BUSY; CMD_READY SHALL be 0 in WR, DONE and ERR.
REQ-019 A transfer (CMD_VALID & CMD_READY) SHALL register the word and check it in the same cycle, then go to WR (if legal) or ERR (if illegal).
REQ-020 In WR, when SEQ_BUSY=0: SRAM_WE=1 for one cycle with SRAM_ADDR=wr_ptr and SRAM_WR_DAT=the registered word; wr_ptr and WORD_CNT increment; the next state is DONE if seq_end=1, else LOAD.
REQ-021 In WR, when SEQ_BUSY=1: SRAM_WE SHALL stay 0 and the FSM SHALL hold in WR until SEQ_BUSY=0.
REQ-022 Throughput SHALL be at most one word per 2 cycles; the write occurs 1 cycle after acceptance.
REQ-023 loop_start while a loop is already open, loop_stop with no loop open, or seq_end with a loop open SHALL give ERR with ERR_CODE=01.
REQ-024 loop_start with data[23:0]=0 SHALL give ERR with ERR_CODE=10.
REQ-025 A word accepted at wr_ptr=2^SRAM_ADDR_WIDTH-1 with seq_end=0 SHALL give ERR with ERR_CODE=11; the address SHALL never wrap.
REQ-026 A word that causes ERR SHALL NOT be written to SRAM.
REQ-027 The loop_open flag SHALL set on a legal loop_start write and clear on a legal loop_stop write; a single word carrying both flags SHALL be legal only when no loop is open, and leaves loop_open=0.
REQ-028 DONE SHALL drive LOAD_DONE=1; ERR SHALL drive LOAD_ERR=1 with ERR_CODE held; both states SHALL persist until CMD_CLR or reset.
REQ-029 CMD_CLR=1 in any state SHALL, on the next edge, go to LOAD with wr_ptr=0, WORD_CNT=0, loop_open=0, LOAD_DONE=0, LOAD_ERR=0, ERR_CODE=00 and SRAM_WE=0.
REQ-030 CMD_CLR coincident with a transfer SHALL take priority; the word SHALL be dropped and not written.

Reset
REQ-031 With RST=0 at a clock edge: state=LOAD, wr_ptr=0, SRAM_ADDR=0, SRAM_WR_DAT=0, SRAM_WE=0, WORD_CNT=0, LOAD_DONE=0, LOAD_ERR=0, ERR_CODE=00, loop_open=0, and CMD_READY=0 during reset.
REQ-032 Reset mid-write SHALL suppress any pending SRAM_WE.
REQ-033 The first transfer after reset SHALL be possible on the first edge with RST=1 and SEQ_BUSY=0.

Verification
REQ-034 Load 0x00000064, 0x20000003, 0x81000010, 0x10000008, 0x40000000 back-to-back -> 5 writes to addresses 0-4 with identical data, WORD_CNT=5, LOAD_DONE=1.
REQ-035 Load 0x20000002 then 0x20000002 -> the second word is not written, LOAD_ERR=1, ERR_CODE=01, WORD_CNT=1.
REQ-036 Load 0x20000000 -> ERR_CODE=10 and no SRAM_WE.
REQ-037 Load 256 words with seq_end=0 -> 255 writes, then ERR_CODE=11, SRAM_ADDR never returns to 0.
REQ-038 Raise SEQ_BUSY during WR -> SRAM_WE is held off until SEQ_BUSY falls, then exactly one write occurs; CMD_READY=0 throughout.
REQ-039 Assert CMD_CLR in DONE, coincident with CMD_VALID -> the word is dropped, the next accepted word is written to address 0, and LOAD_DONE=0.
